// File: rtl/vec_strided_lsu_pkg.sv
// Shared definitions for the strided vector load/store sequencer.
//   - SEW encodings as they arrive on the sew command field
//   - FSM state encoding of the sequencer
//   - helpers giving the element byte mask and base byte strobe per SEW
package vec_lsu_pkg;

    localparam logic [1:0] SEW_E8  = 2'd0;
    localparam logic [1:0] SEW_E16 = 2'd1;
    localparam logic [1:0] SEW_E32 = 2'd2;
    localparam logic [1:0] SEW_ILL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_NEXT = 2'd2,
        ST_FIN  = 2'd3
    } lsu_state_e;

    // Bit mask covering the low SEW bits of a 32-bit word.
    function automatic logic [31:0] sew_mask(input logic [1:0] sew);
        case (sew)
            SEW_E8:  return 32'h0000_00FF;
            SEW_E16: return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Byte enables of an element placed at byte lane 0.
    function automatic logic [3:0] sew_strb(input logic [1:0] sew);
        case (sew)
            SEW_E8:  return 4'b0001;
            SEW_E16: return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/vec_strided_lsu_if.sv
// Data-memory port of the strided LSU: a single valid/ready request channel
// with the read data returned in the same cycle as mem_ready.
//   mem_valid  master->slave  request valid, held until mem_ready
//   mem_ready  slave->master  one-cycle acknowledge
//   mem_addr   master->slave  byte address of the element
//   mem_wdata  master->slave  lane-aligned store data
//   mem_wstrb  master->slave  byte enables (0 for loads)
//   mem_rdata  slave->master  load word, valid with mem_ready
interface vec_strided_lsu_if;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/vec_strided_lsu_align.sv
// vec_lane_align: purely combinational byte-lane steering for one element.
//   sew_i       element width code
//   addr_lo_i   low two bits of the element byte address
//   st_data_i   element read from the VRF (low SEW bits used)
//   rdata_i     memory word returned for a load
//   wdata_o     store data shifted into its byte lanes
//   wstrb_o     store byte enables
//   ld_data_o   load element extracted and zero-extended
//   misalign_o  element does not sit on its natural SEW boundary
module vec_lane_align
    import vec_lsu_pkg::*;
(
    input  logic [1:0]  sew_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] ld_data_o,
    output logic        misalign_o
);

    logic [4:0] sh;

    assign sh = {addr_lo_i, 3'b000};

    assign wdata_o   = (st_data_i & sew_mask(sew_i)) << sh;
    assign wstrb_o   = sew_strb(sew_i) << addr_lo_i;
    assign ld_data_o = (rdata_i >> sh) & sew_mask(sew_i);

    assign misalign_o = ((sew_i == SEW_E16) && addr_lo_i[0]) ||
                        ((sew_i == SEW_E32) && (addr_lo_i != 2'b00));

endmodule

// File: rtl/vec_strided_lsu.sv
// vec_strided_lsu: executes one vlse.v / vsse.v per start strobe, walking
// vl elements at base + i*stride and issuing one memory request each.
//   clk, reset            clock, asynchronous active-high reset
//   start, is_store, base, stride, vl, sew
//                         command, sampled only when idle
//   busy, done, err       status; err qualifies the done pulse
//   mem                   data-memory request channel (master side)
//   st_idx, st_data       VRF read port used by stores
//   ld_we, ld_idx, ld_data VRF write port used by loads
module vec_strided_lsu
    import vec_lsu_pkg::*;
#(
    parameter int VL_W = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                is_store,
    input  logic [31:0]         base,
    input  logic [31:0]         stride,
    input  logic [VL_W-1:0]     vl,
    input  logic [1:0]          sew,
    output logic                busy,
    output logic                done,
    output logic                err,
    vec_strided_lsu_if.master   mem,
    output logic [VL_W-1:0]     st_idx,
    input  logic [31:0]         st_data,
    output logic                ld_we,
    output logic [VL_W-1:0]     ld_idx,
    output logic [31:0]         ld_data
);

    lsu_state_e      state_q;
    logic            is_store_q;
    logic [31:0]     stride_q;
    logic [VL_W-1:0] vl_q;
    logic [1:0]      sew_q;
    logic [VL_W-1:0] idx_q;
    logic [31:0]     addr_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            ld_we_q;
    logic [VL_W-1:0] ld_idx_q;
    logic [31:0]     ld_data_q;

    logic [31:0]     addr_d;
    logic [VL_W-1:0] idx_d;
    logic [31:0]     al_wdata;
    logic [3:0]      al_wstrb;
    logic [31:0]     al_ld_data;
    logic            misalign;
    logic            req_vld;

    // Address arithmetic wraps naturally modulo 2^32 for any stride sign.
    assign addr_d = addr_q + stride_q;
    assign idx_d  = idx_q + VL_W'(1);

    vec_lane_align u_align (
        .sew_i      (sew_q),
        .addr_lo_i  (addr_q[1:0]),
        .st_data_i  (st_data),
        .rdata_i    (mem.mem_rdata),
        .wdata_o    (al_wdata),
        .wstrb_o    (al_wstrb),
        .ld_data_o  (al_ld_data),
        .misalign_o (misalign)
    );

    // A misaligned element never raises a request; the FSM aborts instead.
    assign req_vld = (state_q == ST_REQ) && !misalign;

    assign mem.mem_valid = req_vld;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = (req_vld && is_store_q) ? al_wdata : 32'h0;
    assign mem.mem_wstrb = (req_vld && is_store_q) ? al_wstrb : 4'h0;

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign st_idx  = busy_q ? idx_q : '0;
    assign ld_we   = ld_we_q;
    assign ld_idx  = ld_idx_q;
    assign ld_data = ld_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            stride_q   <= '0;
            vl_q       <= '0;
            sew_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ld_we_q    <= 1'b0;
            ld_idx_q   <= '0;
            ld_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        is_store_q <= is_store;
                        stride_q   <= stride;
                        vl_q       <= vl;
                        sew_q      <= sew;
                        idx_q      <= '0;
                        addr_q     <= base;
                        busy_q     <= 1'b1;
                        // Empty or illegal commands complete without memory traffic.
                        if ((vl == '0) || (sew == SEW_ILL)) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                            err_q   <= (sew == SEW_ILL);
                        end else begin
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (misalign) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else if (mem.mem_ready) begin
                        state_q <= ST_NEXT;
                        if (!is_store_q) begin
                            ld_we_q   <= 1'b1;
                            ld_idx_q  <= idx_q;
                            ld_data_q <= al_ld_data;
                        end
                    end
                end
                ST_NEXT: begin
                    ld_we_q <= 1'b0;
                    addr_q  <= addr_d;
                    idx_q   <= idx_d;
                    if (idx_d == vl_q) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_strided_lsu.sv
module tb_vec_strided_lsu;

    localparam int VL_W = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            is_store;
    logic [31:0]     base;
    logic [31:0]     stride;
    logic [VL_W-1:0] vl;
    logic [1:0]      sew;
    logic            busy, done, err, ld_we;
    logic [VL_W-1:0] st_idx, ld_idx;
    logic [31:0]     st_data, ld_data;

    vec_strided_lsu_if mem_if ();

    vec_strided_lsu #(.VL_W(VL_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .is_store (is_store),
        .base     (base),
        .stride   (stride),
        .vl       (vl),
        .sew      (sew),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem      (mem_if.master),
        .st_idx   (st_idx),
        .st_data  (st_data),
        .ld_we    (ld_we),
        .ld_idx   (ld_idx),
        .ld_data  (ld_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic [31:0] vrf [0:1023];

    assign st_data = vrf[st_idx];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: the list of transactions a command must produce.
    logic [31:0] q_addr[$];
    logic [31:0] q_wdata[$];
    logic [3:0]  q_wstrb[$];
    int          q_ldi[$];
    logic [31:0] q_ldd[$];
    bit          m_err;

    task automatic build_model(input bit st, input logic [31:0] b, input logic [31:0] s,
                               input int v, input int sw);
        logic [31:0] a, mask;
        int size;
        q_addr.delete(); q_wdata.delete(); q_wstrb.delete();
        q_ldi.delete();  q_ldd.delete();
        m_err = (sw == 3);
        if (sw != 3) begin
            size = 1 << sw;
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
            for (int i = 0; i < v; i++) begin
                a = b + s * 32'(i);
                if ((a % size) != 0) begin
                    m_err = 1'b1;
                    break;
                end
                q_addr.push_back(a);
                if (st) begin
                    q_wdata.push_back((vrf[i] & mask) << (8 * a[1:0]));
                    q_wstrb.push_back(4'(((1 << size) - 1) << a[1:0]));
                end else begin
                    q_wdata.push_back(32'h0);
                    q_wstrb.push_back(4'h0);
                    q_ldi.push_back(i);
                    q_ldd.push_back((mem[a[11:2]] >> (8 * a[1:0])) & mask);
                end
            end
        end
    endtask

    task automatic scramble();
        is_store = 1'($urandom);
        base     = $urandom;
        stride   = $urandom;
        vl       = VL_W'($urandom);
        sew      = 2'($urandom);
    endtask

    // lat < 0 selects a random acknowledge delay of 0..2 cycles per request.
    task automatic run_cmd(input bit st, input logic [31:0] b, input logic [31:0] s,
                           input int v, input int sw, input int lat, input int hold_idx,
                           input int hold_len, input bit restart, input int exp_cyc);
        int c, nreq, nld, wcnt;
        bit pending, rdy, got_done;
        logic [31:0] held_addr, a;
        build_model(st, b, s, v, sw);
        start = 1'b1; is_store = st; base = b; stride = s; vl = VL_W'(v); sew = 2'(sw);
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        c = 1; nreq = 0; nld = 0; wcnt = 0;
        pending = 0; rdy = 0; got_done = 0; held_addr = 0;
        chk("busy_rise", busy, 1);
        while (!got_done && c < 600) begin
            if (rdy) pending = 0;
            rdy = 0;
            mem_if.mem_rdata = $urandom;
            if (mem_if.mem_valid) begin
                a = mem_if.mem_addr;
                if (!pending) begin
                    pending = 1; held_addr = a;
                    if (nreq < q_addr.size()) begin
                        chk("addr", a, q_addr[nreq]);
                        chk("wdata", mem_if.mem_wdata, q_wdata[nreq]);
                        chk("wstrb", 32'(mem_if.mem_wstrb), 32'(q_wstrb[nreq]));
                        if (st) chk("st_idx", 32'(st_idx), 32'(nreq));
                    end else begin
                        chk("extra_req", 32'(nreq), 32'(q_addr.size()));
                    end
                    wcnt = (nreq == hold_idx) ? hold_len :
                           (lat < 0) ? int'($urandom_range(0, 2)) : lat;
                    nreq++;
                end else begin
                    chk("hold_addr", a, held_addr);
                end
                if (wcnt == 0) begin
                    rdy = 1;
                    if (st) begin
                        for (int k = 0; k < 4; k++)
                            if (mem_if.mem_wstrb[k]) mem[a[11:2]][8*k +: 8] = mem_if.mem_wdata[8*k +: 8];
                    end else begin
                        mem_if.mem_rdata = mem[a[11:2]];
                    end
                end else begin
                    wcnt--;
                end
            end
            mem_if.mem_ready = rdy;
            if (ld_we) begin
                if (nld < q_ldi.size()) begin
                    chk("ld_idx", 32'(ld_idx), 32'(q_ldi[nld]));
                    chk("ld_data", ld_data, q_ldd[nld]);
                end else begin
                    chk("extra_ld", 32'(nld), 32'(q_ldi.size()));
                end
                nld++;
            end
            if (done) begin
                got_done = 1;
                chk("err", 32'(err), 32'(m_err));
                chk("req_count", 32'(nreq), 32'(q_addr.size()));
                chk("ld_count", 32'(nld), 32'(q_ldi.size()));
                if (exp_cyc >= 0) chk("done_cycle", 32'(c), 32'(exp_cyc));
            end
            if (restart && c == 2) begin
                scramble();
                start = 1'b1;
            end else begin
                start = 1'b0;
                scramble();
            end
            @(posedge clk); #1;
            c++;
        end
        mem_if.mem_ready = 1'b0;
        start = 1'b0;
        if (!got_done) chk("timeout", 0, 1);
        chk("busy_fall", busy, 0);
    endtask

    initial begin
        int sw, size, v, cnt;
        logic [31:0] s, b;
        reset = 1'b1; start = 1'b0; is_store = 0; base = 0; stride = 0; vl = 0; sew = 0;
        mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            vrf[i] = $urandom;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", mem_if.mem_valid, 0);
        chk("rst_addr", mem_if.mem_addr, 0);
        chk("rst_wstrb", 32'(mem_if.mem_wstrb), 0);
        chk("rst_ld_we", ld_we, 0);
        chk("rst_st_idx", 32'(st_idx), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Aligned word load, fixed one-cycle acknowledge delay.
        begin
            logic [31:0] pat [16];
            pat = '{2,1,2,1,1,3,1,0,2,1,2,1,1,3,1,0};
            for (int i = 0; i < 16; i++) mem[100 + i] = pat[i];
        end
        run_cmd(0, 400, 4, 16, 2, 1, -1, 0, 0, 49);

        // Byte store walking all four lanes of one word.
        for (int i = 0; i < 4; i++) vrf[i] = 32'h11 * (i + 1);
        run_cmd(1, 800, 1, 4, 0, -1, -1, 0, 0, -1);
        chk("mem_word200", mem[200], 32'h4433_2211);

        // Misaligned second element aborts the command.
        run_cmd(0, 400, 1, 16, 2, -1, -1, 0, 0, -1);

        // Negative stride wrapping below zero, fourth request stalled.
        run_cmd(0, 8, 32'hFFFF_FFFC, 4, 2, 1, 3, 6, 0, -1);

        // Degenerate commands.
        run_cmd(0, 100, 4, 0, 2, -1, -1, 0, 0, 1);
        run_cmd(1, 100, 4, 5, 3, -1, -1, 0, 0, 1);

        // Start strobe while busy must not disturb the running command.
        run_cmd(1, 32'h100, 2, 6, 1, -1, -1, 0, 1, -1);

        // Reset in the middle of a request.
        start = 1'b1; is_store = 0; base = 0; stride = 4; vl = 8; sew = 2;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst_pre_valid", mem_if.mem_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", mem_if.mem_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_ld_we", ld_we, 0);
        chk("arst_addr", mem_if.mem_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || mem_if.mem_valid) cnt++;
            @(posedge clk); #1;
        end
        chk("rst_quiet", 32'(cnt), 0);
        run_cmd(0, 400, 4, 3, 2, -1, -1, 0, 0, -1);

        // Randomized commands.
        for (int t = 0; t < 16; t++) begin
            sw = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            size = 1 << (sw == 3 ? 0 : sw);
            v = $urandom_range(0, 10);
            s = 32'(($urandom_range(0, 8) - 4) * size);
            if ($urandom_range(0, 5) == 0) s = s + 32'd1;
            b = $urandom & ~(32'(size) - 32'd1);
            for (int i = 0; i < 16; i++) vrf[i] = $urandom;
            run_cmd(1'($urandom), b, s, v, sw, -1, -1, 0, 1'($urandom), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
